// File: rtl/counter_nch_if.sv
// Register-window bus between the MIO decoder and counter_nch.
// Handshake: we is a one-cycle write strobe with no back-pressure; rdata is combinational from addr.
interface counter_nch_if #(
    parameter int AW = 4
);
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/counter_nch.sv
// N-channel programmable down-counter/timer with prescaler, reload, three modes and sticky done/irq.
// Defining COUNTER_CHAIN_EN adds CTRL bit4 CHAIN: channel k ticks on the expiry of channel k-1.
module counter_nch #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic            clk,
    input  logic            RSTN,
    counter_nch_if.slave    bus,
    output logic [N_CH-1:0] ch_out,
    output logic [N_CH-1:0] irq,
    output logic            irq_any
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW   = CH_W + 2;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_SQUARE   = 2'd2;

    logic [CH_W-1:0] ch_idx;
    logic [1:0]      reg_idx;
    logic [31:0]     unused_wdata;

    assign ch_idx       = bus.addr[AW-1:2];
    assign reg_idx      = bus.addr[1:0];
    assign unused_wdata = bus.wdata;

    logic             en_q     [N_CH];
    logic [1:0]       mode_q   [N_CH];
    logic             irq_en_q [N_CH];
    logic [PRE_W-1:0] pre_q    [N_CH];
    logic [PRE_W-1:0] psc_q    [N_CH];
    logic [CNT_W-1:0] load_q   [N_CH];
    logic [CNT_W-1:0] count_q  [N_CH];
    logic             done_q   [N_CH];
    logic             out_q    [N_CH];
    logic             pulse_q  [N_CH];
`ifdef COUNTER_CHAIN_EN
    logic             chain_q  [N_CH];
    logic             exp_q    [N_CH];
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic sel;
        logic ctrl_wr;
        logic load_wr;
        logic stat_wr;
        logic chained;
        logic base_tick;
        logic tick;
        logic expire;
        logic oneshot;

        assign sel     = bus.we && (ch_idx == CH_W'(k));
        assign ctrl_wr = sel && (reg_idx == REG_CTRL);
        assign load_wr = sel && (reg_idx == REG_LOAD);
        assign stat_wr = sel && (reg_idx == REG_STATUS);
        // Mode 3 is reserved and behaves as one-shot.
        assign oneshot = (mode_q[k] != MODE_PERIODIC) && (mode_q[k] != MODE_SQUARE);

`ifdef COUNTER_CHAIN_EN
        if (k > 0) begin : g_link
            assign chained   = chain_q[k];
            assign base_tick = chain_q[k] ? exp_q[k-1] : (psc_q[k] == pre_q[k]);
        end else begin : g_head
            assign chained   = 1'b0;
            assign base_tick = (psc_q[k] == pre_q[k]);
        end
`else
        assign chained   = 1'b0;
        assign base_tick = (psc_q[k] == pre_q[k]);
`endif

        // A LOAD write or a disabling CTRL write swallows a coincident tick.
        assign tick   = en_q[k] && base_tick && !load_wr && !(ctrl_wr && !bus.wdata[0]);
        assign expire = tick && (count_q[k] <= CNT_W'(1));

        always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN) begin
                en_q[k]     <= 1'b0;
                mode_q[k]   <= 2'd0;
                irq_en_q[k] <= 1'b0;
                pre_q[k]    <= '0;
                psc_q[k]    <= '0;
                load_q[k]   <= '0;
                count_q[k]  <= '0;
                done_q[k]   <= 1'b0;
                out_q[k]    <= 1'b0;
                pulse_q[k]  <= 1'b0;
`ifdef COUNTER_CHAIN_EN
                chain_q[k]  <= 1'b0;
                exp_q[k]    <= 1'b0;
`endif
            end else begin
                if (ctrl_wr) begin
                    en_q[k]     <= bus.wdata[0];
                    mode_q[k]   <= bus.wdata[2:1];
                    irq_en_q[k] <= bus.wdata[3];
                    pre_q[k]    <= bus.wdata[8 +: PRE_W];
`ifdef COUNTER_CHAIN_EN
                    chain_q[k]  <= (k > 0) ? bus.wdata[4] : 1'b0;
`endif
                end
                if (expire && oneshot)
                    en_q[k] <= 1'b0;

                if (!en_q[k] || chained || (ctrl_wr && !bus.wdata[0]) || (psc_q[k] == pre_q[k]))
                    psc_q[k] <= '0;
                else
                    psc_q[k] <= psc_q[k] + 1'b1;

                if (load_wr) begin
                    load_q[k]  <= bus.wdata[CNT_W-1:0];
                    count_q[k] <= bus.wdata[CNT_W-1:0];
                end else if (expire) begin
                    count_q[k] <= oneshot ? '0 : load_q[k];
                end else if (tick) begin
                    count_q[k] <= count_q[k] - 1'b1;
                end

                if (expire)
                    done_q[k] <= 1'b1;
                else if (stat_wr && bus.wdata[0])
                    done_q[k] <= 1'b0;

                // pulse_q marks a level we raised for one cycle, so a square level survives mode changes.
                if (expire) begin
                    out_q[k]   <= (mode_q[k] == MODE_SQUARE) ? ~out_q[k] : 1'b1;
                    pulse_q[k] <= (mode_q[k] != MODE_SQUARE);
                end else if (pulse_q[k]) begin
                    out_q[k]   <= 1'b0;
                    pulse_q[k] <= 1'b0;
                end
`ifdef COUNTER_CHAIN_EN
                exp_q[k] <= expire;
`endif
            end
        end

        assign ch_out[k] = out_q[k];
        assign irq[k]    = done_q[k] & irq_en_q[k];
    end

    assign irq_any = |irq;

    always_comb begin
        bus.rdata = '0;
        if (int'(ch_idx) < N_CH) begin
            case (reg_idx)
                REG_CTRL: begin
                    bus.rdata[0]          = en_q[ch_idx];
                    bus.rdata[2:1]        = mode_q[ch_idx];
                    bus.rdata[3]          = irq_en_q[ch_idx];
`ifdef COUNTER_CHAIN_EN
                    bus.rdata[4]          = chain_q[ch_idx];
`endif
                    bus.rdata[8 +: PRE_W] = pre_q[ch_idx];
                end
                REG_LOAD:  bus.rdata[CNT_W-1:0] = load_q[ch_idx];
                REG_COUNT: bus.rdata[CNT_W-1:0] = count_q[ch_idx];
                default:   bus.rdata[0]         = done_q[ch_idx];
            endcase
        end
    end
endmodule
